shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; 1 enables two's-complement mode via signed_mode, 0 forces unsigned operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands a, b, signed_mode are presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1 = treat a, b, p as two's complement; ignored when SIGNED_EN=0.
REQ-010 out_valid  output  1  p holds a completed product.
REQ-011 out_ready  input  1  consumer takes p.
REQ-012 p  output  2*WIDTH  product.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept: on a rising edge with in_valid & in_ready, the block SHALL latch a, b, effective mode (signed_mode & SIGNED_EN), clear the accumulator, load bit counter with WIDTH, and enter RUN.
REQ-016 Signed mode: at accept, operands SHALL be converted to WIDTH-bit magnitudes and the result sign latched as sign(a) XOR sign(b); magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) (no overflow).
REQ-017 RUN: each cycle the block SHALL add the shifted multiplicand magnitude to the accumulator if the current multiplier bit (LSB first) is 1, shift, and decrement the counter; exactly WIDTH cycles spent in RUN, with no early termination on zero operands.
REQ-018 On the last RUN cycle the block SHALL register p = accumulator result, two's-complement negated if latched sign is 1, and enter DONE.
REQ-019 Latency: out_valid SHALL go high exactly WIDTH+1 rising edges after the accepting edge.
REQ-020 Product width: p SHALL be the exact 2*WIDTH-bit product; no truncation or saturation in either mode (signed range -2^(2W-2)+... up to +2^(2W-2) fits).
REQ-021 DONE: p and out_valid SHALL stay stable until an edge with out_ready=1, then the block SHALL enter IDLE; out_ready while not DONE SHALL have no effect.
REQ-022 in_valid while not IDLE SHALL be ignored; operands SHALL NOT be sampled except on the accepting edge.
REQ-023 Changes on a, b, signed_mode during RUN/DONE SHALL not affect p.
REQ-024 Minimum accept-to-accept interval SHALL be WIDTH+3 cycles (accept, WIDTH RUN, DONE handshake, IDLE).
REQ-025 p SHALL retain its last value in IDLE until the next product is registered.

Reset
REQ-026 While rst=1 on a rising edge: state=IDLE, in_ready=1 after the edge, out_valid=0, busy=0, p=0, accumulator and counter=0.
REQ-027 Reset SHALL take priority over accept and handshake; reset during RUN or DONE SHALL abort the operation with no product emitted.

Verification
REQ-028 WIDTH=4, unsigned: a=4'hF, b=4'hF, accept -> out_valid after 5 edges, p=8'hE1; matches 4x4 array-multiplier results for all 256 operand pairs.
REQ-029 WIDTH=8, signed: a=8'h80 (-128), b=8'h80 -> p=16'h4000; a=8'h80, b=8'h7F -> p=16'hC080; a=8'hFF, b=8'h01 -> p=16'hFFFF.
REQ-030 WIDTH=8, SIGNED_EN=0 with signed_mode=1: a=8'hFF, b=8'hFF -> p=16'hFE01 (unsigned).
REQ-031 Backpressure: out_ready=0 for 10 cycles in DONE -> p and out_valid stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 rst asserted at RUN cycle 3 with a=8'd200, b=8'd3 -> next edge state IDLE, out_valid=0, p=0; no product emitted.
REQ-033 Random back-to-back stream (1000 ops, random in_valid/out_ready, both modes) -> every p equals reference model, order preserved, none lost or duplicated.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH RUN cycles per product, optional
// two's-complement mode, valid/ready handshake on both the operand and the product side.
module shift_add_multiplier #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic        SIGNED_OK = (SIGNED_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [PW-1:0]      r_p;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_eff_mode;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [PW-1:0]      w_acc_step;
    logic [PW-1:0]      w_prod;
    logic               w_accept;
    logic               w_last_run;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned magnitude
    assign w_eff_mode = signed_mode & SIGNED_OK;
    assign w_a_neg    = w_eff_mode & a[WIDTH-1];
    assign w_b_neg    = w_eff_mode & b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag    = w_b_neg ? (~b + WIDTH'(1)) : b;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last_run = (r_state == S_RUN) && (r_cnt == CW'(1));

    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : PW'(0));
    assign w_prod     = r_neg ? (~w_acc_step + PW'(1)) : w_acc_step;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Handshake flags follow the next state so they are valid right after each edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Datapath: multiplicand shifts left, multiplier shifts right, one bit per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= PW'(w_a_mag);
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_neg    <= w_a_neg ^ w_b_neg;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last_run) begin
                r_p <= w_prod;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: an 8-bit signed-capable instance plus a 4-bit unsigned-only
// instance swept over every operand pair.
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, signed mode available
    logic        in_valid0, in_ready0, m0, out_valid0, out_ready0, busy0;
    logic [7:0]  a0, b0;
    logic [15:0] p0;

    // 4-bit, signed mode disabled
    logic        in_valid1, in_ready1, m1, out_valid1, out_ready1, busy1;
    logic [3:0]  a1, b1;
    logic [7:0]  p1;

    shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .signed_mode(m0), .out_valid(out_valid0),
        .out_ready(out_ready0), .p(p0), .busy(busy0)
    );

    shift_add_multiplier #(.WIDTH(4), .SIGNED_EN(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .signed_mode(m1), .out_valid(out_valid1),
        .out_ready(out_ready1), .p(p1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_push0 = 0;
    int n_pop0 = 0;
    logic [15:0] q0[$];
    logic [7:0]  q1[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic m);
        int sa;
        int sb;
        sa = m ? int'($signed(a)) : int'({24'd0, a});
        sb = m ? int'($signed(b)) : int'({24'd0, b});
        return 16'(sa * sb);
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        int ua;
        int ub;
        ua = int'({28'd0, a});
        ub = int'({28'd0, b});
        return 8'(ua * ub);
    endfunction

    // Scoreboard for the 8-bit instance: handshakes are judged at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
        end else begin
            if (out_valid0 && out_ready0) begin
                n_pop0++;
                if (q0.size() == 0) begin
                    chk("p8_unexpected", 64'(p0), 64'hDEAD);
                end else begin
                    chk("p8_scoreboard", 64'(p0), 64'(q0.pop_front()));
                end
            end
            if (in_valid0 && in_ready0) begin
                q0.push_back(ref8(a0, b0, m0));
                n_push0++;
            end
        end
    end

    task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input logic m,
                           input logic [15:0] exp, input string tag);
        int n;
        @(posedge clk); #1;
        a0 = a; b0 = b; m0 = m; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        a0 = ~a; b0 = ~b; m0 = ~m;
        n = 1;
        while (!out_valid0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd9);
        chk(tag, 64'(p0), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic backpressure();
        int n;
        logic [15:0] exp;
        exp = ref8(8'h12, 8'hCC, 1'b1);
        out_ready0 = 1'b0;
        @(posedge clk); #1;
        a0 = 8'h12; b0 = 8'hCC; m0 = 1'b1; in_valid0 = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid0 && n < 40) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); in_valid0 = 1'b1;
            chk("bp_out_valid", 64'(out_valid0), 64'd1);
            chk("bp_p", 64'(p0), 64'(exp));
            chk("bp_in_ready", 64'(in_ready0), 64'd0);
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid0), 64'd0);
        chk("bp_release_ready", 64'(in_ready0), 64'd1);
        chk("bp_release_busy", 64'(busy0), 64'd0);
        chk("idle_p_hold", 64'(p0), 64'(exp));
    endtask

    task automatic reset_mid_run();
        int seen;
        @(posedge clk); #1;
        a0 = 8'd200; b0 = 8'd3; m0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        chk("abort_busy", 64'(busy0), 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready0), 64'd1);
        chk("abort_out_valid", 64'(out_valid0), 64'd0);
        chk("abort_busy_low", 64'(busy0), 64'd0);
        chk("abort_p", 64'(p0), 64'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid0) seen++;
        end
        chk("abort_no_product", 64'(seen), 64'd0);
    endtask

    task automatic random_stream();
        int cyc;
        int push_start;
        int pop_start;
        push_start = n_push0;
        pop_start = n_pop0;
        cyc = 0;
        while ((n_push0 - push_start) < 1000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid0  = ($urandom_range(0, 3) != 0);
            out_ready0 = ($urandom_range(0, 3) != 0);
            a0 = 8'($urandom); b0 = 8'($urandom); m0 = 1'($urandom);
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        cyc = 0;
        while ((q0.size() != 0 || out_valid0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_pushed", 64'(n_push0 - push_start), 64'd1000);
        chk("rand_popped", 64'(n_pop0 - pop_start), 64'd1000);
        chk("rand_queue_empty", 64'(q0.size()), 64'd0);
    endtask

    // Every 4-bit operand pair, signed_mode held high to show it is ignored
    task automatic sweep4();
        int idx;
        int cyc;
        logic [7:0] pair;
        idx = 0; cyc = 0;
        a1 = 4'd0; b1 = 4'd0; m1 = 1'b1;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        while ((idx < 256 || q1.size() != 0) && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (out_valid1) begin
                if (q1.size() == 0) chk("p4_unexpected", 64'(p1), 64'hDEAD);
                else chk("p4_scoreboard", 64'(p1), 64'(q1.pop_front()));
            end
            if (in_valid1 && in_ready1) begin
                q1.push_back(ref4(a1, b1));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 256) begin
                pair = 8'(idx);
                a1 = pair[7:4];
                b1 = pair[3:0];
            end else begin
                in_valid1 = 1'b0;
            end
        end
        chk("sweep4_count", 64'(idx), 64'd256);
        chk("sweep4_queue_empty", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; m0 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_p", 64'(p0), 64'd0);
        chk("rst4_in_ready", 64'(in_ready1), 64'd1);
        chk("rst4_p", 64'(p1), 64'd0);
        rst = 1'b0;
        out_ready0 = 1'b1;

        run_op0(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_m128");
        run_op0(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128_127");
        run_op0(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_1");
        run_op0(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255_255");
        run_op0(8'h03, 8'hFD, 1'b1, 16'hFFF7, "s_3_m3");
        run_op0(8'h00, 8'h80, 1'b1, 16'h0000, "s_0_m128");

        backpressure();
        reset_mid_run();
        random_stream();
        sweep4();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
